spi_master_data_path: RTL and testbench
=======================================

SPI_MASTER_DATA_PATH -- requirements
Module: spi_master_data_path

Interface
REQ-001 Parameter HALF_DIV, default 4, clk cycles per sclk half-period; values below 4 are illegal because the slave synchronizer needs at least 4.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; accepted only in IDLE.
REQ-005 spi_mode  input  2  01 single, 10 dual, 11 quad; 00 is invalid.
REQ-006 addr / status / wdata  input  20/4/16  frame fields, captured on accepted start.
REQ-007 burst_more  input  1  sampled at each word end to continue a burst.
REQ-008 miso  input  4  serial read lanes from the slave.
REQ-009 sclk, cs_n  output  1/1  SPI clock (idle low) and chip select (idle high).
REQ-010 mosi  output  4  serial write lanes; unused lanes are driven 0.
REQ-011 rdata / rdata_valid  output  16/1  read word and its one-cycle strobe.
REQ-012 word_done, busy, done, mode_err  output  1 each  word-end pulse; high when not IDLE; frame-end pulse; invalid-mode pulse.

Function
REQ-013 Lane width W is 1, 2 or 4 according to spi_mode; spi_mode is registered on start and held for the whole frame.
REQ-014 Start with spi_mode=00 shall be dropped, pulse mode_err for one cycle, and leave cs_n high.
REQ-015 FSM states and transitions shall be IDLE -> SETUP -> ADDR -> STAT -> TURN -> DATA -> (TAIL when reading) -> HOLD -> GAP -> IDLE.
REQ-016 SETUP: cs_n goes low; the first sclk rise comes HALF_DIV clks later.
REQ-017 mosi shall change only at sclk rising edges and stay stable through the following falling edge.
REQ-018 Lane mapping: in each sclk cycle, mosi[j] = field[i+j] for j < W, then i advances by W; fields are sent LSB first.
REQ-019 ADDR shall take 20/W sclk cycles, carrying addr.
REQ-020 STAT shall take 4/W sclk cycles, carrying status.
REQ-021 TURN shall take 8/W sclk cycles with mosi=0.
REQ-022 DATA shall take 16/W sclk cycles.
REQ-023 Write (status[2]=1): DATA drives wdata on mosi; miso is ignored.
REQ-024 Read (status[2]=0): mosi=0; miso lanes are sampled on sclk falling edges.
REQ-025 Read capture lags DATA by one sclk cycle: the first falling edge of DATA is discarded, and one extra TAIL sclk cycle supplies the last lane group.
REQ-026 Read assembly: rdata[i+j] = miso[j] for each sampled lane group, LSB first.
REQ-027 rdata_valid shall pulse one cycle after the last falling-edge sample, with rdata updated in the same cycle; rdata holds its value until the next read completes.
REQ-028 word_done shall pulse at the last falling edge of each word, i.e. the end of DATA for writes and the end of TAIL for reads.
REQ-029 Burst continue: if status[1]=1 and burst_more=1 in the word_done cycle, the FSM re-enters DATA with cs_n still low and the bit index cleared; a write burst re-captures wdata in that same cycle.
REQ-030 Burst end: with status[1]=0 or burst_more=0 at word_done, the FSM goes to HOLD.
REQ-031 HOLD: sclk stays low for HALF_DIV clks, then cs_n rises.
REQ-032 GAP: cs_n stays high for 2*HALF_DIV clks; done pulses on the GAP exit cycle.
REQ-033 start while busy is ignored, and the captured fields do not change.
REQ-034 Clock divider: a counter counts 0..HALF_DIV-1 and toggles sclk at wrap, only in ADDR/STAT/TURN/DATA/TAIL; sclk always ends low.
REQ-035 Field index counters shall be log2-sized and wrap to 0 at each phase boundary; no phase may skip or repeat a lane group.

Reset
REQ-036 Asserting reset_n=0 at any time, including mid-frame, forces IDLE with cs_n=1 and sclk=0.
REQ-037 Reset also forces mosi=0, rdata=0 and every strobe to 0, and clears all counters and captured fields.
REQ-038 After reset release the block shall accept start on the first clk edge.

Structure
REQ-039 A shared package spi_pkg holds the mode encodings, field widths (20/4/8/16), the status bit indices (WRITE=2, BURST=1) and the FSM state enum.
REQ-040 The sclk divider shall be one sub-module, spi_sclk_gen, with outputs rise_pulse and fall_pulse.

Verification
REQ-041 Single-lane write: addr=0xA5A5A, status=0b0100, wdata=0x1234 -> 48 sclk cycles; slave model decodes addr 0xA5A5A and wdata 0x1234; done pulses once.
REQ-042 Quad-lane read: slave returns 0xBEEF -> 13 sclk cycles (12 plus TAIL); rdata=0xBEEF with a one-cycle rdata_valid.
REQ-043 Dual-lane write burst: status=0b0110, burst_more=1 for the first word, wdata 0x1111 then 0x2222 -> cs_n stays low across both words; two word_done pulses; slave receives both words.
REQ-044 start with spi_mode=00 -> mode_err pulse; cs_n stays 1; busy stays 0.
REQ-045 reset_n=0 during the ADDR phase -> cs_n=1 and sclk=0 immediately; a later single-lane write completes correctly.
REQ-046 start pulsed while busy -> ignored; frame contents unchanged versus the scoreboard.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared encodings, field widths, FSM states and lane helpers
// for the SPI master data path.
package spi_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_DUAL   = 2'b10;
  localparam logic [1:0] MODE_QUAD   = 2'b11;

  localparam int ADDR_W = 20;
  localparam int STAT_W = 4;
  localparam int TURN_W = 8;
  localparam int DATA_W = 16;

  localparam int ST_WRITE = 2;
  localparam int ST_BURST = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_ADDR, S_STAT, S_TURN,
    S_DATA, S_TAIL, S_HOLD, S_GAP
  } state_e;

  typedef struct packed {
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [STAT_W-1:0] stat;
    logic [DATA_W-1:0] wdata;
  } frame_t;

  function automatic logic [2:0] lane_w(input logic [1:0] m);
    case (m)
      MODE_QUAD: lane_w = 3'd4;
      MODE_DUAL: lane_w = 3'd2;
      default:   lane_w = 3'd1;
    endcase
  endfunction

  function automatic logic [4:0] phase_len(input state_e s,
                                           input logic [1:0] m);
    case (s)
      S_ADDR:  phase_len = 5'(ADDR_W);
      S_STAT:  phase_len = 5'(STAT_W);
      S_TURN:  phase_len = 5'(TURN_W);
      S_DATA:  phase_len = 5'(DATA_W);
      S_TAIL:  phase_len = {2'b00, lane_w(m)};
      default: phase_len = 5'd0;
    endcase
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      S_ADDR:  next_phase = S_STAT;
      S_STAT:  next_phase = S_TURN;
      S_TURN:  next_phase = S_DATA;
      default: next_phase = S_TAIL;
    endcase
  endfunction

  function automatic logic [3:0] lane_out(input logic [19:0] f,
                                          input logic [4:0]  i,
                                          input logic [1:0]  m);
    logic [3:0] r;
    r = 4'(f >> i);
    case (m)
      MODE_QUAD: lane_out = r;
      MODE_DUAL: lane_out = r & 4'b0011;
      default:   lane_out = r & 4'b0001;
    endcase
  endfunction

  function automatic logic [15:0] rx_shift(input logic [15:0] rx,
                                           input logic [3:0]  mi,
                                           input logic [1:0]  m);
    case (m)
      MODE_QUAD: rx_shift = {mi, rx[15:4]};
      MODE_DUAL: rx_shift = {mi[1:0], rx[15:2]};
      default:   rx_shift = {mi[0], rx[15:1]};
    endcase
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: toggles sclk every HALF_DIV clks while enabled,
// flagging the clk edge on which sclk rises or falls.
module spi_sclk_gen #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          wrap;

  assign wrap       = en && (cnt_q == CW'(HALF_DIV - 1));
  assign rise_pulse = wrap && !sclk_q;
  assign fall_pulse = wrap && sclk_q;
  assign sclk       = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_data_path.sv
// SPI master frame engine: addr/status/turnaround/data phases over
// 1, 2 or 4 lanes with optional word bursts.
module spi_master_data_path
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  spi_mode,
  input  logic [19:0] addr,
  input  logic [3:0]  status,
  input  logic [15:0] wdata,
  input  logic        burst_more,
  input  logic [3:0]  miso,
  output logic        sclk,
  output logic        cs_n,
  output logic [3:0]  mosi,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        word_done,
  output logic        busy,
  output logic        done,
  output logic        mode_err
);

  localparam int WCW = $clog2(2 * HALF_DIV);

  state_e         state_q;
  frame_t         frm_q;
  logic [4:0]     idx_q;
  logic [WCW-1:0] wcnt_q;
  logic           cs_n_q;
  logic [3:0]     mosi_q;
  logic [15:0]    rx_q;
  logic [15:0]    rdata_q;
  logic           rdata_valid_q;
  logic           word_done_q;
  logic           done_q;
  logic           mode_err_q;

  logic        en, rise, fall;
  logic [2:0]  w;
  logic        is_wr, last, wend, more;
  state_e      ph;
  logic [19:0] fld;
  logic [15:0] rx_d;

  assign en = state_q inside {S_SETUP, S_ADDR, S_STAT,
                              S_TURN, S_DATA, S_TAIL};

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
    .clk        (clk),
    .rst_n      (reset_n),
    .en         (en),
    .sclk       (sclk),
    .rise_pulse (rise),
    .fall_pulse (fall)
  );

  assign w     = lane_w(frm_q.mode);
  assign is_wr = frm_q.stat[ST_WRITE];
  assign more  = frm_q.stat[ST_BURST] && burst_more;
  assign ph    = (state_q == S_SETUP) ? S_ADDR : state_q;
  assign last  = idx_q == phase_len(state_q, frm_q.mode);
  assign wend  = fall && last &&
                 ((state_q == S_DATA && is_wr) || state_q == S_TAIL);
  assign rx_d  = rx_shift(rx_q, miso, frm_q.mode);

  always_comb begin
    fld = '0;
    case (ph)
      S_ADDR:  fld = frm_q.addr;
      S_STAT:  fld = {16'b0, frm_q.stat};
      S_DATA:  fld = is_wr ? {4'b0, frm_q.wdata} : '0;
      default: fld = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      frm_q         <= '0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      cs_n_q        <= 1'b1;
      mosi_q        <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      word_done_q   <= 1'b0;
      done_q        <= 1'b0;
      mode_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      word_done_q   <= 1'b0;
      done_q        <= 1'b0;
      mode_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && spi_mode == 2'b00) begin
            mode_err_q <= 1'b1;
          end else if (start) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            frm_q   <= '{spi_mode, addr, status, wdata};
            idx_q   <= '0;
          end
        end
        S_HOLD: begin
          if (wcnt_q == WCW'(HALF_DIV - 1)) begin
            state_q <= S_GAP;
            cs_n_q  <= 1'b1;
            mosi_q  <= '0;
            wcnt_q  <= '0;
          end else begin
            wcnt_q  <= wcnt_q + WCW'(1);
          end
        end
        S_GAP: begin
          if (wcnt_q == WCW'(2 * HALF_DIV - 1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            wcnt_q  <= '0;
          end else begin
            wcnt_q  <= wcnt_q + WCW'(1);
          end
        end
        default: begin
          if (rise) begin
            state_q <= ph;
            mosi_q  <= lane_out(fld, idx_q, frm_q.mode);
            idx_q   <= idx_q + 5'(w);
          end
          if (fall) begin
            // Read data lags one sclk cycle: drop the first DATA sample
            if (state_q == S_DATA && !is_wr &&
                idx_q != {2'b00, w}) begin
              rx_q <= rx_d;
            end
            if (state_q == S_TAIL) begin
              rx_q          <= rx_d;
              rdata_q       <= rx_d;
              rdata_valid_q <= 1'b1;
            end
            if (last) begin
              idx_q <= '0;
              if (wend) begin
                word_done_q <= 1'b1;
                if (more) begin
                  state_q <= S_DATA;
                  if (is_wr) frm_q.wdata <= wdata;
                end else begin
                  state_q <= S_HOLD;
                  wcnt_q  <= '0;
                end
              end else begin
                state_q <= next_phase(state_q);
              end
            end
          end
        end
      endcase
    end
  end

  assign cs_n        = cs_n_q;
  assign mosi        = mosi_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign word_done   = word_done_q;
  assign done        = done_q;
  assign mode_err    = mode_err_q;
  assign busy        = state_q != S_IDLE;

endmodule

// File: tb/tb_spi_master_data_path.sv
// Directed bench for spi_master_data_path with a lane-aware slave
// model sampling the bus on the falling clk edge.
module tb_spi_master_data_path;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  spi_mode = 2'b01;
  logic [19:0] addr = '0;
  logic [3:0]  status = '0;
  logic [15:0] wdata = '0;
  logic        burst_more = 1'b0;
  logic [3:0]  miso = '0;
  logic        sclk, cs_n, rdata_valid, word_done, busy, done, mode_err;
  logic [3:0]  mosi;
  logic [15:0] rdata;

  int checks = 0;
  int failures = 0;

  spi_master_data_path #(.HALF_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .spi_mode(spi_mode),
    .addr(addr), .status(status), .wdata(wdata),
    .burst_more(burst_more), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .rdata(rdata), .rdata_valid(rdata_valid),
    .word_done(word_done), .busy(busy), .done(done),
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // slave model / monitor state
  int           tb_w = 1;
  logic [15:0]  sl_rword = '0;
  logic [127:0] sl_bits = '0;
  int sl_nb = 0, sl_rises = 0, clk_cnt = 0;
  int m_done = 0, m_wd = 0, m_rv = 0, m_merr = 0;
  int m_csfall = 0, m_csrise = 0;
  int stab_err = 0, lane_err = 0, sclk_cs_err = 0;
  int t_csfall = 0, t_rise1 = 0, t_lfall = 0, t_csrise = 0, t_done = 0;
  logic [15:0] m_rdata = '0;
  logic sclk_p = 1'b0, cs_p = 1'b1, rst_p = 1'b0;
  logic [3:0] mosi_p = '0;

  always @(negedge clk) begin
    int d;
    logic [15:0] tmp;
    logic [3:0] msk;
    clk_cnt++;
    msk = (tb_w == 4) ? 4'hF : (tb_w == 2) ? 4'h3 : 4'h1;
    if (!cs_n && cs_p) begin
      m_csfall++; t_csfall = clk_cnt;
      sl_nb = 0; sl_rises = 0; sl_bits = '0;
    end
    if (cs_n && !cs_p) begin m_csrise++; t_csrise = clk_cnt; end
    if (sclk && !sclk_p) begin
      sl_rises++;
      if (sl_rises == 1) t_rise1 = clk_cnt;
      d = sl_rises - 32 / tb_w - 1;
      if (d >= 1 && d <= 16 / tb_w) begin
        tmp = sl_rword >> ((d - 1) * tb_w);
        miso = tmp[3:0] & msk;
      end else begin
        miso = '0;
      end
    end
    if (!sclk && sclk_p) begin
      t_lfall = clk_cnt;
      for (int j = 0; j < 4; j++)
        if (j < tb_w && sl_nb + j < 128) sl_bits[sl_nb + j] = mosi[j];
      sl_nb += tb_w;
    end
    if (reset_n && rst_p && sclk_p && mosi !== mosi_p) stab_err++;
    if ((mosi & ~msk) !== 4'h0) lane_err++;
    if (sclk && cs_n) sclk_cs_err++;
    if (done) begin m_done++; t_done = clk_cnt; end
    if (word_done) m_wd++;
    if (rdata_valid) begin m_rv++; m_rdata = rdata; end
    if (mode_err) m_merr++;
    sclk_p = sclk; cs_p = cs_n; mosi_p = mosi; rst_p = reset_n;
  end

  task automatic kick(input logic [1:0] m, input logic [19:0] a,
                      input logic [3:0] s, input logic [15:0] d);
    @(negedge clk);
    spi_mode = m; addr = a; status = s; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (m_done > base) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, sclk, busy} !== 3'b100) begin
      failures++;
      $display("FAIL rst_ctrl got cs/sclk/busy=%b exp=100", {cs_n, sclk, busy});
    end
    checks++;
    if (mosi !== 4'h0 || rdata !== 16'h0) begin
      failures++;
      $display("FAIL rst_data got mosi=%h rdata=%h exp 0/0", mosi, rdata);
    end
    checks++;
    if ({rdata_valid, word_done, done, mode_err} !== 4'b0) begin
      failures++;
      $display("FAIL rst_strobes got=%b exp=0000",
               {rdata_valid, word_done, done, mode_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    bit ok;
    int b0;
    b0 = m_done;
    tb_w = 1;
    kick(2'b01, 20'hA5A5A, 4'b0100, 16'h1234);
    wait_done(b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr1_timeout got=none exp=done"); end
    checks++;
    if (sl_rises !== 48) begin
      failures++; $display("FAIL wr1_sclk got=%0d exp=48", sl_rises);
    end
    checks++;
    if (sl_bits[19:0] !== 20'hA5A5A || sl_bits[23:20] !== 4'b0100) begin
      failures++;
      $display("FAIL wr1_addr_stat got=%h/%b exp=a5a5a/0100",
               sl_bits[19:0], sl_bits[23:20]);
    end
    checks++;
    if (sl_bits[31:24] !== 8'h0 || sl_bits[47:32] !== 16'h1234) begin
      failures++;
      $display("FAIL wr1_turn_data got=%h/%h exp=00/1234",
               sl_bits[31:24], sl_bits[47:32]);
    end
    checks++;
    if (m_done - b0 !== 1 || m_rv !== 0) begin
      failures++;
      $display("FAIL wr1_pulses got done=%0d rv=%0d exp 1/0", m_done - b0, m_rv);
    end
    checks++;
    if (t_rise1 - t_csfall !== 4 || t_csrise - t_lfall !== 4 ||
        t_done - t_csrise !== 8) begin
      failures++;
      $display("FAIL wr1_timing got setup=%0d hold=%0d gap=%0d exp 4/4/8",
               t_rise1 - t_csfall, t_csrise - t_lfall, t_done - t_csrise);
    end
  endtask

  task automatic test_quad_read;
    bit ok;
    int b0, r0, w0;
    b0 = m_done; r0 = m_rv; w0 = m_wd;
    tb_w = 4; sl_rword = 16'hBEEF;
    kick(2'b11, 20'h12345, 4'b0000, 16'hFFFF);
    wait_done(b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rdq_timeout got=none exp=done"); end
    checks++;
    if (sl_rises !== 13) begin
      failures++; $display("FAIL rdq_sclk got=%0d exp=13", sl_rises);
    end
    checks++;
    if (rdata !== 16'hBEEF || m_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL rdq_data got=%h strobe=%h exp=beef", rdata, m_rdata);
    end
    checks++;
    if (m_rv - r0 !== 1 || m_wd - w0 !== 1) begin
      failures++;
      $display("FAIL rdq_pulses got rv=%0d wd=%0d exp 1/1", m_rv - r0, m_wd - w0);
    end
    checks++;
    if (sl_bits[19:0] !== 20'h12345 || sl_bits[51:24] !== 28'h0) begin
      failures++;
      $display("FAIL rdq_mosi got addr=%h rest=%h exp 12345/0",
               sl_bits[19:0], sl_bits[51:24]);
    end
  endtask

  task automatic test_dual_burst;
    bit ok;
    int b0, w0, f0, r0;
    b0 = m_done; w0 = m_wd; f0 = m_csfall; r0 = m_csrise;
    tb_w = 2;
    kick(2'b10, 20'h3C3C3, 4'b0110, 16'h1111);
    wdata = 16'h2222; burst_more = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (m_wd > w0) ok = 1'b1;
    end
    burst_more = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL brst_wd1 got=none exp=word_done"); end
    wait_done(b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL brst_timeout got=none exp=done"); end
    checks++;
    if (sl_rises !== 32 || m_wd - w0 !== 2) begin
      failures++;
      $display("FAIL brst_count got sclk=%0d wd=%0d exp 32/2", sl_rises, m_wd - w0);
    end
    checks++;
    if (sl_bits[47:32] !== 16'h1111 || sl_bits[63:48] !== 16'h2222 ||
        sl_bits[23:0] !== 24'h63C3C3) begin
      failures++;
      $display("FAIL brst_data got=%h %h hdr=%h exp 1111 2222 63c3c3",
               sl_bits[47:32], sl_bits[63:48], sl_bits[23:0]);
    end
    checks++;
    if (m_csfall - f0 !== 1 || m_csrise - r0 !== 1) begin
      failures++;
      $display("FAIL brst_cs got falls=%0d rises=%0d exp 1/1",
               m_csfall - f0, m_csrise - r0);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin
      failures++; $display("FAIL rdata_hold got=%h exp=beef", rdata);
    end
  endtask

  task automatic test_mode_err;
    int f0, e0;
    f0 = m_csfall; e0 = m_merr;
    kick(2'b00, 20'h11111, 4'b0100, 16'hAAAA);
    checks++;
    if ({mode_err, busy, cs_n} !== 3'b101) begin
      failures++;
      $display("FAIL merr_pulse got err/busy/cs=%b exp=101", {mode_err, busy, cs_n});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (m_merr - e0 !== 1 || m_csfall - f0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL merr_after got errs=%0d csfalls=%0d busy=%b exp 1/0/0",
               m_merr - e0, m_csfall - f0, busy);
    end
  endtask

  task automatic test_start_busy;
    bit ok;
    int b0, f0;
    b0 = m_done; f0 = m_csfall;
    tb_w = 1;
    kick(2'b01, 20'h13579, 4'b0100, 16'h5A5A);
    while (sl_rises < 10 && busy) @(negedge clk);
    spi_mode = 2'b11; addr = 20'hFFFFF; status = 4'b0010;
    wdata = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_timeout got=none exp=done"); end
    checks++;
    if (sl_rises !== 48 || sl_bits[19:0] !== 20'h13579 ||
        sl_bits[47:32] !== 16'h5A5A || m_csfall - f0 !== 1) begin
      failures++;
      $display("FAIL busy_frame got sclk=%0d addr=%h data=%h falls=%0d exp 48/13579/5a5a/1",
               sl_rises, sl_bits[19:0], sl_bits[47:32], m_csfall - f0);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int b0;
    tb_w = 1;
    kick(2'b01, 20'h77777, 4'b0100, 16'h9999);
    while (sl_rises < 3 && busy) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cs_n, sclk, busy, mosi} !== 7'b1000000 || rdata !== 16'h0) begin
      failures++;
      $display("FAIL midrst got cs/sclk/busy/mosi=%b rdata=%h exp 1000000/0",
               {cs_n, sclk, busy, mosi}, rdata);
    end
    @(negedge clk);
    b0 = m_done;
    reset_n = 1'b1;
    spi_mode = 2'b01; addr = 20'h0F0F1; status = 4'b0100;
    wdata = 16'hCAFE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rst_first_edge got busy=%b exp=1", busy);
    end
    wait_done(b0, ok);
    checks++;
    if (!ok || sl_rises !== 48 || sl_bits[19:0] !== 20'h0F0F1 ||
        sl_bits[47:32] !== 16'hCAFE) begin
      failures++;
      $display("FAIL post_rst_wr got ok=%0d sclk=%0d addr=%h data=%h exp 1/48/0f0f1/cafe",
               ok, sl_rises, sl_bits[19:0], sl_bits[47:32]);
    end
  endtask

  task automatic test_integrity;
    checks++;
    if (stab_err !== 0 || lane_err !== 0 || sclk_cs_err !== 0) begin
      failures++;
      $display("FAIL bus_integrity got stab=%0d lane=%0d sclk_cs=%0d exp 0/0/0",
               stab_err, lane_err, sclk_cs_err);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_quad_read;
    test_dual_burst;
    test_mode_err;
    test_start_busy;
    test_reset_mid_frame;
    test_integrity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
